pipeline_decode: RTL

//  IF/ID pipeline register plus decode-stage control for the 5-stage DLX pipe.

---
 rtl/pipeline_decode_pkg.sv | 51 +++++
 rtl/pipeline_decode_hazard_detect.sv | 48 ++++
 rtl/pipeline_decode.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipeline_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_decode_pkg
// Description : DLX opcode constants, instruction field positions and small
//               decode helpers shared by the ID stage and its hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_decode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQZ     = 6'h04;
    localparam logic [5:0] OP_BNEZ     = 6'h05;
    localparam logic [5:0] OP_JR       = 6'h12;
    localparam logic [5:0] OP_JALR     = 6'h13;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_STORE_LO = 6'h28;
    localparam logic [5:0] OP_STORE_HI = 6'h2B;

    // Instruction field bit ranges
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;
    localparam int IMM_HI = 15;
    localparam int VAL_HI = 25;

    // R-type and stores read rs2 as a real source operand
    function automatic logic f_uses_rs2(input logic [5:0] op);
        return (op == OP_RTYPE) || ((op >= OP_STORE_LO) && (op <= OP_STORE_HI));
    endfunction

    // Instructions resolved in ID that consume rs1 right away
    function automatic logic f_is_id_branch(input logic [5:0] op);
        return (op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_JR) || (op == OP_JALR);
    endfunction

    function automatic logic f_is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_JR) || (op == OP_JALR);
    endfunction

    function automatic logic f_is_jump_reg(input logic [5:0] op);
        return (op == OP_JR) || (op == OP_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_decode_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational stall detection for the ID stage.
//               - load-use against the load currently in EX
//               - ID-resolved branch/jump-register operand against an ALU
//                 result in EX or a load in MEM
// Ports       : i_rs1/i_rs2         source registers of the ID instruction
//               i_uses_rs2          ID instruction reads rs2
//               i_is_branch         ID instruction reads rs1 in ID
//               i_id_ex_*           EX-stage write/load/destination
//               i_ex_mem_*          MEM-stage load/destination
//               o_stall             hazard present (caller gates with valid)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect (
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_uses_rs2,
    input  logic       i_is_branch,
    input  logic       i_id_ex_reg_write,
    input  logic       i_id_ex_mem_read,
    input  logic [4:0] i_id_ex_rd,
    input  logic       i_ex_mem_mem_read,
    input  logic [4:0] i_ex_mem_rd,
    output logic       o_stall
);

    logic w_ex_rd_nz;
    logic w_mem_rd_nz;
    logic w_load_use;
    logic w_branch_ex;
    logic w_branch_mem;

    // r0 is hardwired to zero, so it never carries a dependency
    assign w_ex_rd_nz  = (i_id_ex_rd  != 5'd0);
    assign w_mem_rd_nz = (i_ex_mem_rd != 5'd0);

    assign w_load_use   = i_id_ex_mem_read & w_ex_rd_nz &
                          ((i_id_ex_rd == i_rs1) | (i_uses_rs2 & (i_id_ex_rd == i_rs2)));

    assign w_branch_ex  = i_id_ex_reg_write & w_ex_rd_nz & (i_id_ex_rd == i_rs1);
    assign w_branch_mem = i_ex_mem_mem_read & w_mem_rd_nz & (i_ex_mem_rd == i_rs1);

    assign o_stall = w_load_use | (i_is_branch & (w_branch_ex | w_branch_mem));

endmodule
`default_nettype wire

// File: rtl/pipeline_decode.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_decode
// Description : IF/ID pipeline register and decode-stage control for the
//               5-stage DLX pipe. Resolves BEQZ/BNEZ/J/JAL/JR/JALR in ID,
//               drives fetch control, detects hazards, keeps saturating
//               stall/flush counters.
// Ports       : clk, resetN (async active-low)
//               instrIn, pcPlus4In, branchTaken      from fetch
//               readData1                            register file port 1
//               idEx*/exMem*                         downstream stage info
//               rs1Addr, rs2Addr                     register file addresses
//               instructionId, idValid, pcPlus4Id    ID stage contents
//               stall, zFlag, nzFlag, BEQZ, BNEZ,
//               jump, jumpReg, value, extendedImm,
//               registerS1                           fetch-stage controls
//               stallCount, flushCount               perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_decode
    import pipeline_decode_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] RESET_PC4 = 32'h0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [31:0]      instrIn,
    input  logic [31:0]      pcPlus4In,
    input  logic             branchTaken,
    input  logic [31:0]      readData1,
    input  logic             idExRegWrite,
    input  logic             idExMemRead,
    input  logic [4:0]       idExRd,
    input  logic             exMemMemRead,
    input  logic [4:0]       exMemRd,
    output logic [4:0]       rs1Addr,
    output logic [4:0]       rs2Addr,
    output logic [31:0]      instructionId,
    output logic             idValid,
    output logic [31:0]      pcPlus4Id,
    output logic             stall,
    output logic             zFlag,
    output logic             nzFlag,
    output logic             BEQZ,
    output logic             BNEZ,
    output logic             jump,
    output logic             jumpReg,
    output logic [25:0]      value,
    output logic [31:0]      extendedImm,
    output logic [31:0]      registerS1,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // IF/ID register
    logic             r_valid;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [5:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_hazard;
    logic       w_stall;
    logic       w_id_valid;
    logic       w_jump;
    logic       w_flush;

    assign w_opcode = r_instr[OPC_HI:OPC_LO];
    assign w_rs1    = r_instr[RS1_HI:RS1_LO];
    assign w_rs2    = r_instr[RS2_HI:RS2_LO];

    hazard_detect u_hazard_detect (
        .i_rs1             (w_rs1),
        .i_rs2             (w_rs2),
        .i_uses_rs2        (f_uses_rs2(w_opcode)),
        .i_is_branch       (f_is_id_branch(w_opcode)),
        .i_id_ex_reg_write (idExRegWrite),
        .i_id_ex_mem_read  (idExMemRead),
        .i_id_ex_rd        (idExRd),
        .i_ex_mem_mem_read (exMemMemRead),
        .i_ex_mem_rd       (exMemRd),
        .o_stall           (w_hazard)
    );

    // A bubble in ID can never be stalled
    assign w_stall    = r_valid & w_hazard;
    assign w_id_valid = r_valid & ~w_stall;
    assign w_jump     = w_id_valid & f_is_jump(w_opcode);
    // No delay slot: whatever fetch presents alongside a redirect is squashed
    assign w_flush    = branchTaken | w_jump;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_pc4   <= RESET_PC4;
        end else if (w_flush) begin
            // Flush wins even if a stall were to coincide
            r_valid <= 1'b0;
            r_instr <= 32'h0;
        end else if (!w_stall) begin
            r_valid <= 1'b1;
            r_instr <= instrIn;
            r_pc4   <= pcPlus4In;
        end
    end

    // Counters saturate at all-ones
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (w_flush && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    assign rs1Addr       = w_rs1;
    assign rs2Addr       = w_rs2;
    assign instructionId = r_instr;
    assign idValid       = w_id_valid;
    assign pcPlus4Id     = r_pc4;
    assign stall         = w_stall;
    assign zFlag         = w_id_valid & (readData1 == 32'h0);
    assign nzFlag        = w_id_valid & (readData1 != 32'h0);
    assign BEQZ          = w_id_valid & (w_opcode == OP_BEQZ);
    assign BNEZ          = w_id_valid & (w_opcode == OP_BNEZ);
    assign jump          = w_jump;
    assign jumpReg       = w_id_valid & f_is_jump_reg(w_opcode);
    assign value         = r_instr[VAL_HI:0];
    assign extendedImm   = {{16{r_instr[IMM_HI]}}, r_instr[IMM_HI:0]};
    assign registerS1    = readData1;
    assign stallCount    = r_stall_cnt;
    assign flushCount    = r_flush_cnt;

endmodule
`default_nettype wire
